msrv32_branch_ctrl: RTL and testbench
=====================================

Name: msrv32_branch_ctrl

Overview:
- Sequences control-transfer resolution in the msrv32 core.
- Consumes the branch-taken decision for the instruction in decode/execute, plus its computed target.
- Issues a registered PC redirect to fetch with a valid/ready handshake, stalls decode until fetch accepts, and flushes the wrong-path instruction.
- Detects misaligned targets and counts accepted redirects for performance monitoring.

Parameters:
- WIDTH, 32, address/data width.
- CNT_WIDTH, 16, width of the redirect counter.

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock, all state on rising edge
- ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset
- valid_in  input  1  instruction in execute is valid
- opcode_6_to_2_in  input  5  opcode[6:2] of that instruction
- funct3_in  input  3  funct3 of that instruction
- branch_taken_in  input  1  taken decision from the branch unit
- target_addr_in  input  WIDTH  computed branch/jump target (JALR bit0 already cleared)
- trap_taken_in  input  1  trap/interrupt redirect, highest priority
- imem_ready_in  input  1  fetch accepts a redirect this cycle
- redirect_valid_out  output  1  redirect request to fetch
- redirect_pc_out  output  WIDTH  redirect address
- stall_out  output  1  hold decode/execute
- flush_out  output  1  kill instruction in fetch/decode
- misaligned_instr_out  output  1  one-cycle pulse: taken target not word aligned
- redirect_count_out  output  CNT_WIDTH  accepted-redirect counter

Behaviour:
- Fixed: one clock; reset is synchronous and active-high. Clock is ms_riscv32_mp_clk_in; reset is ms_riscv32_mp_rst_in.
- All outputs are registered. On reset:
  - state=IDLE
  - redirect_valid_out=0, stall_out=0, flush_out=0, misaligned_instr_out=0
  - redirect_pc_out=0, redirect_count_out=0
- is_ctrl when any of:
  - opcode==OP_BRANCH (5'b11000)
  - opcode==OP_JAL (5'b11011)
  - opcode==OP_JALR (5'b11001) with funct3==3'b000
- take = valid_in & is_ctrl & branch_taken_in. It is evaluated only in IDLE.
- misaligned = take & (target_addr_in[1:0] != 2'b00).
- IDLE:
  - take & !misaligned -> REDIRECT next cycle, with redirect_valid_out=1, redirect_pc_out=target_addr_in, stall_out=1, flush_out=1.
  - take & misaligned -> misaligned_instr_out=1 for exactly one cycle; no redirect; remain IDLE.
  - Otherwise remain IDLE with all pulses low.
- REDIRECT:
  - Hold redirect_valid_out, redirect_pc_out, stall_out=1 and flush_out=1 stable until imem_ready_in=1 is sampled.
  - Handshake (redirect_valid_out & imem_ready_in) -> FLUSH next cycle and redirect_count_out += 1.
  - Minimum latency from take to fetch redirect is 1 cycle; there is no upper bound, because the block waits on fetch.
- FLUSH:
  - Exactly one cycle: redirect_valid_out=0, stall_out=0, flush_out=1.
  - valid_in/take are ignored, since that instruction is wrong-path.
  - -> IDLE.
- trap_taken_in=1 in any state -> IDLE next cycle, all outputs except counter cleared. Any pending redirect is discarded and a simultaneous take is ignored. The counter does not increment even if imem_ready_in was high that cycle.
- Counter wraps from 2^CNT_WIDTH-1 to 0 and is never reset by trap.
- Reset asserted mid-REDIRECT/FLUSH -> reset values next cycle; it overrides trap.
- Unused opcodes, or valid_in=0, never cause a redirect regardless of branch_taken_in.

Decomposition:
- Package msrv32_pkg holds:
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR, and FUNCT3_JALR=3'b000.
  - State encoding IDLE=2'b00, REDIRECT=2'b01, FLUSH=2'b10.
- One sub-module, msrv32_redirect_counter: CNT_WIDTH wrapping counter with sync reset and increment enable.
- The FSM and output registers stay in msrv32_branch_ctrl.

Test Plan:
- BEQ taken, target 0x0000_0100, imem_ready_in=1 -> next cycle redirect_valid_out=1, redirect_pc_out=0x100, stall_out=1, flush_out=1. Following cycle FLUSH (flush_out=1, stall_out=0), then IDLE; counter=1.
- JAL taken, target 0x0000_2000, imem_ready_in=0 for 3 cycles then 1 -> redirect_valid_out/redirect_pc_out stable for 4 cycles, then FLUSH, then IDLE; counter increments once.
- JALR funct3=3'b001 with branch_taken_in=1, and opcode 5'b01100 with branch_taken_in=1 -> no redirect, no stall, counter unchanged.
- BNE taken, target 0x0000_0102 -> misaligned_instr_out high for exactly one cycle; redirect_valid_out stays 0; state IDLE.
- In REDIRECT, trap_taken_in=1 with imem_ready_in=1 in the same cycle -> IDLE next cycle, all outputs 0, counter unchanged. Repeat with reset asserted in FLUSH -> reset values next cycle, counter=0.
- Preload counter to 16'hFFFF via 65535 redirects (or force) and perform one more accepted redirect -> redirect_count_out=16'h0000.

Source files
------------

// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared opcode constants and branch-control state encoding
package msrv32_pkg;

    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [2:0] FUNCT3_JALR = 3'b000;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        FLUSH    = 2'b10
    } branch_state_t;

    // True for BRANCH, JAL and the only legal JALR encoding
    function automatic logic is_ctrl_op(input logic [4:0] opcode, input logic [2:0] funct3);
        return (opcode == OP_BRANCH) || (opcode == OP_JAL) ||
               ((opcode == OP_JALR) && (funct3 == FUNCT3_JALR));
    endfunction

endpackage

// File: rtl/msrv32_redirect_counter.sv
// rtl/msrv32_redirect_counter.sv - wrapping accepted-redirect counter
module msrv32_redirect_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_en,
    output logic [CNT_WIDTH-1:0] count
);

    // Free-running wrap; only a hard reset clears it, traps leave it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc_en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/msrv32_branch_ctrl.sv
// rtl/msrv32_branch_ctrl.sv - control-transfer redirect sequencer with fetch handshake
module msrv32_branch_ctrl
    import msrv32_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 ms_riscv32_mp_clk_in,
    input  logic                 ms_riscv32_mp_rst_in,
    input  logic                 valid_in,
    input  logic [4:0]           opcode_6_to_2_in,
    input  logic [2:0]           funct3_in,
    input  logic                 branch_taken_in,
    input  logic [WIDTH-1:0]     target_addr_in,
    input  logic                 trap_taken_in,
    input  logic                 imem_ready_in,
    output logic                 redirect_valid_out,
    output logic [WIDTH-1:0]     redirect_pc_out,
    output logic                 stall_out,
    output logic                 flush_out,
    output logic                 misaligned_instr_out,
    output logic [CNT_WIDTH-1:0] redirect_count_out
);

    branch_state_t state, state_next;

    logic             take;
    logic             misaligned;
    logic             valid_next;
    logic [WIDTH-1:0] pc_next;
    logic             stall_next;
    logic             flush_next;
    logic             mis_next;
    logic             count_inc;

    assign take       = valid_in & is_ctrl_op(opcode_6_to_2_in, funct3_in) & branch_taken_in;
    assign misaligned = take & (target_addr_in[1:0] != 2'b00);

    // State and registered outputs; reset beats everything, including trap
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state                <= IDLE;
            redirect_valid_out   <= 1'b0;
            redirect_pc_out      <= '0;
            stall_out            <= 1'b0;
            flush_out            <= 1'b0;
            misaligned_instr_out <= 1'b0;
        end else begin
            state                <= state_next;
            redirect_valid_out   <= valid_next;
            redirect_pc_out      <= pc_next;
            stall_out            <= stall_next;
            flush_out            <= flush_next;
            misaligned_instr_out <= mis_next;
        end
    end

    // Next state and next output values; trap discards any pending redirect
    always_comb begin
        state_next = state;
        valid_next = 1'b0;
        pc_next    = redirect_pc_out;
        stall_next = 1'b0;
        flush_next = 1'b0;
        mis_next   = 1'b0;
        count_inc  = 1'b0;

        if (trap_taken_in) begin
            state_next = IDLE;
            pc_next    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take && !misaligned) begin
                        state_next = REDIRECT;
                        valid_next = 1'b1;
                        pc_next    = target_addr_in;
                        stall_next = 1'b1;
                        flush_next = 1'b1;
                    end else if (misaligned) begin
                        mis_next = 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redirect_valid_out && imem_ready_in) begin
                        state_next = FLUSH;
                        flush_next = 1'b1;
                        count_inc  = 1'b1;
                    end else begin
                        valid_next = 1'b1;
                        stall_next = 1'b1;
                        flush_next = 1'b1;
                    end
                end
                FLUSH: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    msrv32_redirect_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_redirect_counter (
        .clk    (ms_riscv32_mp_clk_in),
        .rst    (ms_riscv32_mp_rst_in),
        .inc_en (count_inc),
        .count  (redirect_count_out)
    );

endmodule

// File: tb/tb_msrv32_branch_ctrl.sv
// tb/tb_msrv32_branch_ctrl.sv - randomized and directed self-checking bench for msrv32_branch_ctrl
module tb_msrv32_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic        taken;
    logic [31:0] target;
    logic        trap;
    logic        ready;

    logic        rv, stall, flush, mis;
    logic [31:0] pc;
    logic [15:0] cnt;

    logic        s_rv, s_stall, s_flush, s_mis;
    logic [31:0] s_pc;
    logic [2:0]  s_cnt;

    int checks   = 0;
    int failures = 0;

    logic        m_rv, m_stall, m_flush, m_mis;
    logic [31:0] m_pc;
    int          m_cnt;

    always #5 clk = ~clk;

    msrv32_branch_ctrl dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .valid_in             (valid),
        .opcode_6_to_2_in     (opcode),
        .funct3_in            (funct3),
        .branch_taken_in      (taken),
        .target_addr_in       (target),
        .trap_taken_in        (trap),
        .imem_ready_in        (ready),
        .redirect_valid_out   (rv),
        .redirect_pc_out      (pc),
        .stall_out            (stall),
        .flush_out            (flush),
        .misaligned_instr_out (mis),
        .redirect_count_out   (cnt)
    );

    msrv32_branch_ctrl #(.CNT_WIDTH(3)) dut_small (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .valid_in             (valid),
        .opcode_6_to_2_in     (opcode),
        .funct3_in            (funct3),
        .branch_taken_in      (taken),
        .target_addr_in       (target),
        .trap_taken_in        (trap),
        .imem_ready_in        (ready),
        .redirect_valid_out   (s_rv),
        .redirect_pc_out      (s_pc),
        .stall_out            (s_stall),
        .flush_out            (s_flush),
        .misaligned_instr_out (s_mis),
        .redirect_count_out   (s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: behaviour described in terms of the visible outputs only
    task automatic model_step();
        bit ctrl, tk;
        if (rst) begin
            m_rv = 0; m_pc = 0; m_stall = 0; m_flush = 0; m_mis = 0; m_cnt = 0;
        end else if (trap) begin
            m_rv = 0; m_pc = 0; m_stall = 0; m_flush = 0; m_mis = 0;
        end else if (m_rv) begin
            m_mis = 0;
            if (ready) begin
                m_rv = 0; m_stall = 0; m_flush = 1;
                m_cnt = (m_cnt + 1) % 65536;
            end
        end else if (m_flush) begin
            m_flush = 0; m_mis = 0;
        end else begin
            ctrl = (opcode == 5'b11000) || (opcode == 5'b11011) ||
                   (opcode == 5'b11001 && funct3 == 3'b000);
            tk = valid && ctrl && taken;
            m_mis = tk && (target % 4 != 0);
            if (tk && !m_mis) begin
                m_rv = 1; m_pc = target; m_stall = 1; m_flush = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("redirect_valid", 32'(rv), 32'(m_rv));
        check("redirect_pc", pc, m_pc);
        check("stall", 32'(stall), 32'(m_stall));
        check("flush", 32'(flush), 32'(m_flush));
        check("misaligned", 32'(mis), 32'(m_mis));
        check("count", 32'(cnt), 32'(m_cnt));
        check("small_count", 32'(s_cnt), 32'(m_cnt % 8));
        check("small_valid", 32'(s_rv), 32'(m_rv));
    endtask

    task automatic idle_inputs();
        valid = 0; opcode = 5'b00000; funct3 = 0; taken = 0;
        target = 0; trap = 0; ready = 0; rst = 0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] tgt);
        valid = 1; opcode = op; funct3 = f3; taken = 1; target = tgt;
    endtask

    initial begin
        logic [4:0] ops [5];
        ops[0] = 5'b11000; ops[1] = 5'b11011; ops[2] = 5'b11001;
        ops[3] = 5'b01100; ops[4] = 5'b00100;

        idle_inputs();
        rst = 1;
        tick();
        check("reset_valid", 32'(rv), 0);
        check("reset_count", 32'(cnt), 0);
        rst = 0;

        // BEQ taken, fetch ready
        issue(5'b11000, 3'b000, 32'h100); ready = 1;
        tick();
        check("beq_valid", 32'(rv), 1);
        check("beq_pc", pc, 32'h100);
        check("beq_stall", 32'(stall), 1);
        valid = 0;
        tick();
        check("beq_flush", 32'(flush), 1);
        check("beq_flush_stall", 32'(stall), 0);
        tick();
        check("beq_count", 32'(cnt), 1);
        check("beq_idle_flush", 32'(flush), 0);

        // JAL taken, fetch busy three cycles
        issue(5'b11011, 3'b000, 32'h2000); ready = 0;
        tick();
        valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("jal_hold_pc", pc, 32'h2000);
            check("jal_hold_valid", 32'(rv), 1);
        end
        ready = 1;
        tick();
        check("jal_flush", 32'(flush), 1);
        check("jal_count", 32'(cnt), 2);
        ready = 0;
        tick();

        // Illegal JALR funct3 and non-control opcode
        issue(5'b11001, 3'b001, 32'h300);
        tick();
        check("jalr_bad_valid", 32'(rv), 0);
        issue(5'b01100, 3'b000, 32'h300);
        tick();
        check("alu_stall", 32'(stall), 0);

        // BNE misaligned
        issue(5'b11000, 3'b001, 32'h102);
        tick();
        check("mis_pulse", 32'(mis), 1);
        valid = 0;
        tick();
        check("mis_pulse_end", 32'(mis), 0);
        check("mis_no_redirect", 32'(rv), 0);

        // Trap with simultaneous handshake
        issue(5'b11000, 3'b000, 32'h400);
        tick();
        valid = 0; trap = 1; ready = 1;
        tick();
        check("trap_valid", 32'(rv), 0);
        check("trap_pc", pc, 0);
        check("trap_count", 32'(cnt), 2);
        trap = 0;

        // Reset during FLUSH
        issue(5'b11011, 3'b000, 32'h500);
        tick();
        valid = 0;
        tick();
        rst = 1;
        tick();
        check("rst_flush", 32'(flush), 0);
        check("rst_count", 32'(cnt), 0);
        rst = 0; ready = 1;

        // Eight accepted redirects wrap the 3-bit counter
        for (int i = 0; i < 8; i++) begin
            issue(5'b11011, 3'b000, 32'h40 * (i + 1));
            tick();
            valid = 0;
            tick();
            tick();
        end
        check("small_wrap", 32'(s_cnt), 0);
        check("wide_after_8", 32'(cnt), 8);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            valid  = 1'($urandom_range(0, 3) != 0);
            opcode = ops[$urandom_range(0, 4)];
            funct3 = 3'($urandom_range(0, 3) == 0 ? $urandom : 0);
            taken  = 1'($urandom_range(0, 2) != 0);
            target = $urandom;
            if ($urandom_range(0, 4) != 0) target[1:0] = 2'b00;
            trap   = 1'($urandom_range(0, 24) == 0);
            ready  = 1'($urandom_range(0, 1));
            rst    = 1'($urandom_range(0, 299) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
